price_select_latch: RTL and testbench



---
 rtl/vend_pkg.sv | 16 +
 rtl/price_select_latch_if.sv | 29 ++
 rtl/prio_enc_n.sv | 24 ++
 rtl/price_select_latch.sv | 90 +++++++++
 tb/tb_price_select_latch.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending datapath types, default sizes and width helper
package vend_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/price_select_latch_if.sv
// rtl/price_select_latch_if.sv - select/price inputs and latched outputs of the price latch
interface price_select_latch_if
  import vend_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF
) ();

  localparam int IDX_W = clog2_min1(N_CH);

  logic [N_CH*WIDTH-1:0] cons;
  logic [N_CH-1:0]       select;
  logic                  clear;
  logic [WIDTH-1:0]      result;
  logic [IDX_W-1:0]      index;
  logic                  valid;
  logic                  multi;

  modport master (
    output cons, select, clear,
    input  result, index, valid, multi
  );

  modport slave (
    input  cons, select, clear,
    output result, index, valid, multi
  );

endinterface

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - combinational lowest-index-wins priority encoder with multi-hit flag
module prio_enc_n
  import vend_pkg::*;
#(
  parameter int N     = N_CH_DEF,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
    any_o   = |req_i;
    multi_o = (req_i & (req_i - N'(1))) != '0;
  end

endmodule

// File: rtl/price_select_latch.sv
// rtl/price_select_latch.sv - captures the highest-priority selected price and holds it until cleared
module price_select_latch
  import vend_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  price_select_latch_if.slave bus
);

  localparam int IDX_W = clog2_min1(N_CH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic [WIDTH-1:0] sel_price;

  prio_enc_n #(.N(N_CH), .IDX_W(IDX_W)) u_enc (
    .req_i   (bus.select),
    .idx_o   (enc_idx),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  always_comb begin
    sel_price = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (enc_idx == IDX_W'(i)) sel_price = bus.cons[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    index_d  = index_q;
    valid_d  = valid_q;
    multi_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d  = HOLD;
          result_d = sel_price;
          index_d  = enc_idx;
          valid_d  = 1'b1;
          multi_d  = enc_multi;
        end
      end
      HOLD: begin
        // Selects and price changes are ignored here; only clear releases the latch.
        if (bus.clear) begin
          state_d  = IDLE;
          result_d = '0;
          index_d  = '0;
          valid_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
    end
  end

  assign bus.result = result_q;
  assign bus.index  = index_q;
  assign bus.valid  = valid_q;
  assign bus.multi  = multi_q;

endmodule

// File: tb/tb_price_select_latch.sv
// tb/tb_price_select_latch.sv - randomized and directed checks of price_select_latch against a reference model
module tb_price_select_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  price_select_latch_if #(.N_CH(4), .WIDTH(8))  if4 ();
  price_select_latch_if #(.N_CH(6), .WIDTH(12)) if6 ();

  price_select_latch #(.N_CH(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  price_select_latch #(.N_CH(6), .WIDTH(12)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: a latched transaction record for the 4-channel instance.
  bit       m_valid;
  bit [7:0] m_res;
  bit [1:0] m_idx;
  bit       m_multi;

  function automatic bit [7:0] price_of(input bit [31:0] c, input int ch);
    return c[ch*8 +: 8];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_idx = 0; m_multi = 0;
  endtask

  // Decide the next record from the rules, using inputs as seen just before the edge.
  task automatic model_step();
    bit [3:0]  s;
    bit [31:0] c;
    s = if4.select;
    c = if4.cons;
    if (!m_valid) begin
      m_multi = 0;
      if (s != 0) begin
        for (int k = 3; k >= 0; k--) if (s[k]) begin m_idx = 2'(k); m_res = price_of(c, k); end
        m_valid = 1;
        m_multi = ($countones(s) > 1);
      end
    end else begin
      m_multi = 0;
      if (if4.clear) begin m_valid = 0; m_res = 0; m_idx = 0; end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    if4.cons = {8'd40, 8'd30, 8'd20, 8'd10}; if4.select = 0; if4.clear = 0;
    if6.cons = '0; if6.select = 0; if6.clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if4.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if4.valid); end
    checks++; if (if4.result !== 8'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", if4.result); end
    checks++; if (if4.index !== 2'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", if4.index); end
    checks++; if (if4.multi !== 1'b0) begin errors++; $display("FAIL reset_multi got=%b exp=0", if4.multi); end
    rst = 0;
    step();
    checks++; if (if4.valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", if4.valid); end
  endtask

  task automatic test_single();
    if4.select = 4'b0100;
    step();
    checks++; if ({if4.valid, if4.result, if4.index, if4.multi} !== {1'b1, 8'd30, 2'd2, 1'b0})
      begin errors++; $display("FAIL single_capture got v=%b r=%0d i=%0d m=%b exp v=1 r=30 i=2 m=0", if4.valid, if4.result, if4.index, if4.multi); end
    if4.select = 0;
    step();
    checks++; if ({if4.valid, if4.result, if4.index} !== {1'b1, 8'd30, 2'd2})
      begin errors++; $display("FAIL single_hold got v=%b r=%0d i=%0d exp v=1 r=30 i=2", if4.valid, if4.result, if4.index); end
    if4.clear = 1;
    step();
    if4.clear = 0;
    checks++; if ({if4.valid, if4.result, if4.index} !== 11'd0)
      begin errors++; $display("FAIL single_clear got v=%b r=%0d i=%0d exp all 0", if4.valid, if4.result, if4.index); end
  endtask

  task automatic test_idle_clear();
    if4.clear = 1;
    step();
    if4.clear = 0;
    checks++; if ({if4.valid, if4.result} !== 9'd0)
      begin errors++; $display("FAIL idle_clear got v=%b r=%0d exp v=0 r=0", if4.valid, if4.result); end
  endtask

  task automatic test_priority_multi();
    if4.select = 4'b0110;
    step();
    checks++; if ({if4.result, if4.index, if4.multi} !== {8'd20, 2'd1, 1'b1})
      begin errors++; $display("FAIL prio_capture got r=%0d i=%0d m=%b exp r=20 i=1 m=1", if4.result, if4.index, if4.multi); end
    step();
    checks++; if (if4.multi !== 1'b0) begin errors++; $display("FAIL multi_pulse got=%b exp=0", if4.multi); end
    if4.select = 0;
  endtask

  task automatic test_frozen();
    if4.cons[15:8] = 8'd99;
    if4.select = 4'b0001;
    step();
    if4.select = 0;
    step();
    checks++; if ({if4.valid, if4.result, if4.index} !== {1'b1, 8'd20, 2'd1})
      begin errors++; $display("FAIL frozen_hold got v=%b r=%0d i=%0d exp v=1 r=20 i=1", if4.valid, if4.result, if4.index); end
    if4.cons[15:8] = 8'd20;
  endtask

  task automatic test_clear_wins();
    if4.clear = 1; if4.select = 4'b1000;
    step();
    if4.clear = 0;
    checks++; if ({if4.valid, if4.result} !== 9'd0)
      begin errors++; $display("FAIL clear_wins got v=%b r=%0d exp v=0 r=0", if4.valid, if4.result); end
    step();
    checks++; if ({if4.valid, if4.result, if4.index} !== {1'b1, 8'd40, 2'd3})
      begin errors++; $display("FAIL recapture got v=%b r=%0d i=%0d exp v=1 r=40 i=3", if4.valid, if4.result, if4.index); end
    step();
    checks++; if ({if4.valid, if4.result, if4.multi} !== {1'b1, 8'd40, 1'b0})
      begin errors++; $display("FAIL no_retrigger got v=%b r=%0d m=%b exp v=1 r=40 m=0", if4.valid, if4.result, if4.multi); end
    if4.select = 0;
  endtask

  task automatic test_async_reset();
    checks++; if (if4.valid !== 1'b1) begin errors++; $display("FAIL pre_async_valid got=%b exp=1", if4.valid); end
    #2 rst = 1;
    #1;
    checks++; if ({if4.valid, if4.result, if4.index} !== 11'd0)
      begin errors++; $display("FAIL async_reset got v=%b r=%0d i=%0d exp all 0", if4.valid, if4.result, if4.index); end
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if4.select = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      if4.clear  = ($urandom_range(0, 3) == 0);
      if4.cons   = $urandom;
      step();
      checks++;
      if ({if4.valid, if4.result, if4.index, if4.multi} !== {m_valid, m_res, m_idx, m_multi})
        begin errors++; $display("FAIL random[%0d] got v=%b r=%0d i=%0d m=%b exp v=%b r=%0d i=%0d m=%b",
          n, if4.valid, if4.result, if4.index, if4.multi, m_valid, m_res, m_idx, m_multi); end
    end
    if4.select = 0; if4.clear = 0;
  endtask

  task automatic test_scaled();
    if6.cons = '0;
    if6.cons[5*12 +: 12] = 12'hABC;
    if6.cons[0 +: 12]    = 12'h123;
    if6.select = 6'b100000;
    @(posedge clk); #1;
    checks++; if ({if6.valid, if6.result, if6.index} !== {1'b1, 12'hABC, 3'd5})
      begin errors++; $display("FAIL scaled_capture got v=%b r=%h i=%0d exp v=1 r=abc i=5", if6.valid, if6.result, if6.index); end
    if6.select = 0; if6.clear = 1;
    @(posedge clk); #1;
    if6.clear = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({if6.valid, if6.result} !== 13'd0)
      begin errors++; $display("FAIL scaled_idle got v=%b r=%h exp v=0 r=0", if6.valid, if6.result); end
    if6.select = 6'b100001;
    @(posedge clk); #1;
    if6.select = 0;
    checks++; if ({if6.result, if6.index, if6.multi} !== {12'h123, 3'd0, 1'b1})
      begin errors++; $display("FAIL scaled_prio got r=%h i=%0d m=%b exp r=123 i=0 m=1", if6.result, if6.index, if6.multi); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_clear();
    test_priority_multi();
    test_frozen();
    test_clear_wins();
    test_async_reset();
    test_random();
    test_scaled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
